// File: rtl/bp_nbf_write_coalescer.sv
// NBF loader front-end: merges sub-block I/O writes into credit-limited cache-block memory writes.
// Build option BP_NBF_COALESCE_MASK_EN: when defined, mem_cmd_mask_o carries the real byte mask.
module bp_nbf_write_coalescer
  #(parameter int paddr_width_p = 40
   ,parameter int block_width_p = 512
   ,parameter int data_width_p  = 64
   ,parameter int mem_credits_p = 4
   ,parameter int timeout_p     = 256
   )
   (input  logic                       clk_i
   ,input  logic                       reset_n_i

   ,input  logic [paddr_width_p-1:0]   io_cmd_addr_i
   ,input  logic [2:0]                 io_cmd_size_i
   ,input  logic [data_width_p-1:0]    io_cmd_data_i
   ,input  logic                       io_cmd_v_i
   ,output logic                       io_cmd_yumi_o

   ,output logic [paddr_width_p-1:0]   io_resp_addr_o
   ,output logic [2:0]                 io_resp_size_o
   ,output logic                       io_resp_v_o
   ,input  logic                       io_resp_ready_i

   ,output logic [paddr_width_p-1:0]   mem_cmd_addr_o
   ,output logic [block_width_p-1:0]   mem_cmd_data_o
   ,output logic [block_width_p/8-1:0] mem_cmd_mask_o
   ,output logic                       mem_cmd_v_o
   ,input  logic                       mem_cmd_yumi_i

   ,input  logic                       mem_resp_v_i

   ,input  logic                       flush_i
   ,output logic                       flush_done_o
   );

   localparam int block_bytes_lp = block_width_p / 8;
   localparam int data_bytes_lp  = data_width_p / 8;
   localparam int off_w_lp       = $clog2(block_bytes_lp);
   localparam int tag_w_lp       = paddr_width_p - off_w_lp;
   localparam int max_size_lp    = $clog2(data_bytes_lp);
   localparam int cred_w_lp      = $clog2(mem_credits_p + 1);
   localparam int timer_w_lp     = (timeout_p > 1) ? $clog2(timeout_p) : 1;
   localparam logic [timer_w_lp-1:0] timer_last_lp =
      timer_w_lp'((timeout_p > 0) ? (timeout_p - 1) : 0);

   typedef enum logic [1:0] {
      e_idle,
      e_fill,
      e_send
   } state_e;

   state_e                     state_q, state_d;
   logic [tag_w_lp-1:0]        tag_q, tag_d;
   logic [block_bytes_lp-1:0]  mask_q, mask_d;
   logic [block_width_p-1:0]   data_q, data_d;
   logic [timer_w_lp-1:0]      timer_q, timer_d;
   logic [cred_w_lp-1:0]       outstanding_q, outstanding_d;

   logic [paddr_width_p-1:0]   ack0_addr_q, ack0_addr_d;
   logic [paddr_width_p-1:0]   ack1_addr_q, ack1_addr_d;
   logic [2:0]                 ack0_size_q, ack0_size_d;
   logic [2:0]                 ack1_size_q, ack1_size_d;
   logic [1:0]                 ack_cnt_q, ack_cnt_d;
   logic [1:0]                 ack_cnt_after_pop;

   logic [off_w_lp-1:0]        cmd_off;
   logic [tag_w_lp-1:0]        cmd_tag;
   logic                       tag_match;
   logic                       fifo_full;
   logic                       accept;
   logic                       credit_avail;
   logic                       send_fire;
   logic                       resp_fire;
   logic                       ack_pop;
   logic [data_bytes_lp-1:0]   wr_size_mask;
   logic [block_bytes_lp-1:0]  wr_mask;
   logic [block_width_p-1:0]   wr_data;
   logic [block_bytes_lp-1:0]  merge_mask;
   logic [block_width_p-1:0]   merge_data;
   logic [paddr_width_p-1:0]   align_mask;

   assign cmd_off      = io_cmd_addr_i[off_w_lp-1:0];
   assign cmd_tag      = io_cmd_addr_i[paddr_width_p-1:off_w_lp];
   assign tag_match    = (cmd_tag == tag_q);
   assign fifo_full    = (ack_cnt_q == 2'd2);
   assign credit_avail = (outstanding_q < cred_w_lp'(mem_credits_p));
   assign align_mask   = paddr_width_p'((64'd1 << io_cmd_size_i) - 64'd1);

   // Place the incoming beat at its byte offset and overlay it on the open block.
   always_comb begin
      wr_size_mask = '0;
      for (int i = 0; i < data_bytes_lp; i++) begin
         wr_size_mask[i] = (i < (1 << io_cmd_size_i));
      end
      wr_mask    = block_bytes_lp'(wr_size_mask) << cmd_off;
      wr_data    = block_width_p'(io_cmd_data_i) << {cmd_off, 3'b000};
      merge_mask = mask_q | wr_mask;
      merge_data = data_q;
      for (int b = 0; b < block_bytes_lp; b++) begin
         if (wr_mask[b]) begin
            merge_data[8*b +: 8] = wr_data[8*b +: 8];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      tag_d       = tag_q;
      mask_d      = mask_q;
      data_d      = data_q;
      timer_d     = timer_q;
      accept      = 1'b0;
      mem_cmd_v_o = 1'b0;
      case (state_q)
         e_idle: begin
            if (io_cmd_v_i && !fifo_full) begin
               accept  = 1'b1;
               tag_d   = cmd_tag;
               mask_d  = merge_mask;
               data_d  = merge_data;
               timer_d = '0;
               state_d = (&merge_mask) ? e_send : e_fill;
            end
         end
         e_fill: begin
            // A write to another block closes this one; it is taken again from IDLE.
            if (flush_i) begin
               state_d = e_send;
            end else if (io_cmd_v_i && !tag_match) begin
               state_d = e_send;
            end else if (io_cmd_v_i && !fifo_full) begin
               accept  = 1'b1;
               mask_d  = merge_mask;
               data_d  = merge_data;
               timer_d = '0;
               state_d = (&merge_mask) ? e_send : e_fill;
            end else begin
               timer_d = timer_q + timer_w_lp'(1);
               if ((timeout_p != 0) && (timer_q == timer_last_lp)) begin
                  state_d = e_send;
               end
            end
         end
         e_send: begin
            mem_cmd_v_o = credit_avail;
            if (credit_avail && mem_cmd_yumi_i) begin
               mask_d  = '0;
               data_d  = '0;
               timer_d = '0;
               state_d = e_idle;
            end
         end
         default: begin
            state_d = e_idle;
         end
      endcase
   end

   assign io_cmd_yumi_o = accept & reset_n_i;

   // A response with nothing outstanding is dropped so the counter cannot wrap.
   always_comb begin
      send_fire     = mem_cmd_v_o & mem_cmd_yumi_i;
      resp_fire     = mem_resp_v_i & (outstanding_q != '0);
      outstanding_d = outstanding_q + cred_w_lp'(send_fire) - cred_w_lp'(resp_fire);
   end

   assign io_resp_v_o    = (ack_cnt_q != 2'd0);
   assign io_resp_addr_o = ack0_addr_q;
   assign io_resp_size_o = ack0_size_q;
   assign ack_pop        = io_resp_v_o & io_resp_ready_i;

   always_comb begin
      ack0_addr_d       = ack0_addr_q;
      ack0_size_d       = ack0_size_q;
      ack1_addr_d       = ack1_addr_q;
      ack1_size_d       = ack1_size_q;
      ack_cnt_after_pop = ack_cnt_q - {1'b0, ack_pop};
      if (ack_pop) begin
         ack0_addr_d = ack1_addr_q;
         ack0_size_d = ack1_size_q;
      end
      if (io_cmd_yumi_o) begin
         if (ack_cnt_after_pop == 2'd0) begin
            ack0_addr_d = io_cmd_addr_i;
            ack0_size_d = io_cmd_size_i;
         end else begin
            ack1_addr_d = io_cmd_addr_i;
            ack1_size_d = io_cmd_size_i;
         end
      end
      ack_cnt_d = ack_cnt_after_pop + {1'b0, io_cmd_yumi_o};
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_q       <= e_idle;
         tag_q         <= '0;
         mask_q        <= '0;
         data_q        <= '0;
         timer_q       <= '0;
         outstanding_q <= '0;
         ack0_addr_q   <= '0;
         ack0_size_q   <= '0;
         ack1_addr_q   <= '0;
         ack1_size_q   <= '0;
         ack_cnt_q     <= '0;
      end else begin
         state_q       <= state_d;
         tag_q         <= tag_d;
         mask_q        <= mask_d;
         data_q        <= data_d;
         timer_q       <= timer_d;
         outstanding_q <= outstanding_d;
         ack0_addr_q   <= ack0_addr_d;
         ack0_size_q   <= ack0_size_d;
         ack1_addr_q   <= ack1_addr_d;
         ack1_size_q   <= ack1_size_d;
         ack_cnt_q     <= ack_cnt_d;
      end
   end

   assign mem_cmd_addr_o = {tag_q, {off_w_lp{1'b0}}};
   assign mem_cmd_data_o = data_q;

`ifdef BP_NBF_COALESCE_MASK_EN
   assign mem_cmd_mask_o = mask_q;
`else
   // Unwritten bytes are held at zero, so the block always replaces memory wholesale.
   assign mem_cmd_mask_o = '1;
`endif

   assign flush_done_o = (state_q == e_idle) & ~(|mask_q)
                       & (outstanding_q == '0) & (ack_cnt_q == 2'd0);

   a_legal_size: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      io_cmd_v_i |-> (io_cmd_size_i <= 3'(max_size_lp)));
   a_aligned_addr: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      io_cmd_v_i |-> ((io_cmd_addr_i & align_mask) == '0));
   a_yumi_has_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      mem_cmd_yumi_i |-> mem_cmd_v_o);

endmodule

// File: tb/tb_bp_nbf_write_coalescer.sv
// Directed self-checking bench for bp_nbf_write_coalescer (512b blocks, 64b beats, 2 credits, timeout 16).
// Honours BP_NBF_COALESCE_MASK_EN when choosing the expected mask/data.
module tb_bp_nbf_write_coalescer;

   logic         clk;
   logic         reset_n_i;
   logic [39:0]  io_cmd_addr_i;
   logic [2:0]   io_cmd_size_i;
   logic [63:0]  io_cmd_data_i;
   logic         io_cmd_v_i;
   logic         io_cmd_yumi_o;
   logic [39:0]  io_resp_addr_o;
   logic [2:0]   io_resp_size_o;
   logic         io_resp_v_o;
   logic         io_resp_ready_i;
   logic [39:0]  mem_cmd_addr_o;
   logic [511:0] mem_cmd_data_o;
   logic [63:0]  mem_cmd_mask_o;
   logic         mem_cmd_v_o;
   logic         mem_cmd_yumi_i;
   logic         mem_resp_v_i;
   logic         flush_i;
   logic         flush_done_o;

   int checks   = 0;
   int failures = 0;
   logic [42:0] ack_q[$];

   bp_nbf_write_coalescer
     #(.paddr_width_p(40)
      ,.block_width_p(512)
      ,.data_width_p(64)
      ,.mem_credits_p(2)
      ,.timeout_p(16)
      )
   dut
     (.clk_i(clk)
     ,.reset_n_i(reset_n_i)
     ,.io_cmd_addr_i(io_cmd_addr_i)
     ,.io_cmd_size_i(io_cmd_size_i)
     ,.io_cmd_data_i(io_cmd_data_i)
     ,.io_cmd_v_i(io_cmd_v_i)
     ,.io_cmd_yumi_o(io_cmd_yumi_o)
     ,.io_resp_addr_o(io_resp_addr_o)
     ,.io_resp_size_o(io_resp_size_o)
     ,.io_resp_v_o(io_resp_v_o)
     ,.io_resp_ready_i(io_resp_ready_i)
     ,.mem_cmd_addr_o(mem_cmd_addr_o)
     ,.mem_cmd_data_o(mem_cmd_data_o)
     ,.mem_cmd_mask_o(mem_cmd_mask_o)
     ,.mem_cmd_v_o(mem_cmd_v_o)
     ,.mem_cmd_yumi_i(mem_cmd_yumi_i)
     ,.mem_resp_v_i(mem_resp_v_i)
     ,.flush_i(flush_i)
     ,.flush_done_o(flush_done_o)
     );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Acks are recorded at the negedge before the handshake edge.
   always @(negedge clk) begin
      if (reset_n_i && io_resp_v_o && io_resp_ready_i) begin
         ack_q.push_back({io_resp_size_o, io_resp_addr_o});
      end
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish, got hang required finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [511:0] observed, input logic [511:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h required %0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [511:0] expandMask(input logic [63:0] m);
      logic [511:0] r;
      r = '0;
      for (int b = 0; b < 64; b++) r[8*b +: 8] = {8{m[b]}};
      return r;
   endfunction

   function automatic logic [511:0] blockData(input logic [63:0] seed);
      logic [511:0] r;
      for (int i = 0; i < 8; i++) r[64*i +: 64] = seed + 64'(i);
      return r;
   endfunction

   // Presents one command and holds it until it is consumed; returns at posedge+1 after the accept.
   task automatic applyStimulus(input logic [39:0] addr, input logic [2:0] size, input logic [63:0] data);
      int   budget = 0;
      logic got    = 1'b0;
      io_cmd_addr_i = addr;
      io_cmd_size_i = size;
      io_cmd_data_i = data;
      io_cmd_v_i    = 1'b1;
      while (!got && budget < 64) begin
         #1;
         if (io_cmd_yumi_o) got = 1'b1;
         @(posedge clk);
         #1;
         budget++;
      end
      io_cmd_v_i = 1'b0;
      if (!got) checkOutput("accept_timeout", 512'(got), 512'd1);
   endtask

   task automatic fillBlock(input logic [39:0] base, input logic [63:0] seed);
      for (int i = 0; i < 8; i++) applyStimulus(base + 40'(8*i), 3'd3, seed + 64'(i));
   endtask

   task automatic respPulse();
      mem_resp_v_i = 1'b1;
      tick();
      mem_resp_v_i = 1'b0;
   endtask

   // Waits for a memory write, checks it against the expected block, then consumes it.
   task automatic expectMem(input string tag, input logic [39:0] exp_addr,
                            input logic [63:0] exp_mask, input logic [511:0] exp_data);
      int wait_cycles = 0;
      while (!mem_cmd_v_o && wait_cycles < 64) begin
         tick();
         wait_cycles++;
      end
      if (!mem_cmd_v_o) begin
         checkOutput({tag, "_timeout"}, 512'(mem_cmd_v_o), 512'd1);
         return;
      end
      checkOutput({tag, "_addr"}, 512'(mem_cmd_addr_o), 512'(exp_addr));
`ifdef BP_NBF_COALESCE_MASK_EN
      checkOutput({tag, "_mask"}, 512'(mem_cmd_mask_o), 512'(exp_mask));
      checkOutput({tag, "_data"}, mem_cmd_data_o & expandMask(exp_mask), exp_data);
`else
      checkOutput({tag, "_mask"}, 512'(mem_cmd_mask_o), 512'({64{1'b1}}));
      checkOutput({tag, "_data"}, mem_cmd_data_o, exp_data);
`endif
      mem_cmd_yumi_i = 1'b1;
      tick();
      mem_cmd_yumi_i = 1'b0;
   endtask

   initial begin
      int cyc;
      reset_n_i       = 1'b0;
      io_cmd_addr_i   = '0;
      io_cmd_size_i   = '0;
      io_cmd_data_i   = '0;
      io_cmd_v_i      = 1'b0;
      io_resp_ready_i = 1'b1;
      mem_cmd_yumi_i  = 1'b0;
      mem_resp_v_i    = 1'b0;
      flush_i         = 1'b0;

      // Reset state, with a command offered to prove nothing is taken in reset.
      repeat (3) tick();
      io_cmd_v_i = 1'b1;
      #1;
      checkOutput("rst_cmd_yumi", 512'(io_cmd_yumi_o), 512'd0);
      checkOutput("rst_mem_v", 512'(mem_cmd_v_o), 512'd0);
      checkOutput("rst_resp_v", 512'(io_resp_v_o), 512'd0);
      io_cmd_v_i = 1'b0;
      tick();
      reset_n_i = 1'b1;
      #1;
      checkOutput("rst_flush_done", 512'(flush_done_o), 512'd1);
      tick();

      // 1: eight 8B writes fill one block.
      ack_q.delete();
      for (int i = 0; i < 8; i++) applyStimulus(40'h80000000 + 40'(8*i), 3'd3, 64'(i + 1));
      checkOutput("t1_latency", 512'(mem_cmd_v_o), 512'd1);
      expectMem("t1", 40'h80000000, {64{1'b1}}, blockData(64'd1));
      tick();
      tick();
      checkOutput("t1_ack_count", 512'(ack_q.size()), 512'd8);
      for (int i = 0; i < 8; i++)
         checkOutput($sformatf("t1_ack%0d", i), 512'(ack_q[i]), 512'({3'd3, 40'h80000000 + 40'(8*i)}));
      respPulse();

      // 2: a write to another block closes the open one and waits.
      applyStimulus(40'h104, 3'd2, 64'hDEADBEEF);
      io_cmd_addr_i = 40'h200;
      io_cmd_size_i = 3'd3;
      io_cmd_data_i = 64'h1122334455667788;
      io_cmd_v_i    = 1'b1;
      #1;
      checkOutput("t2_stall_fill", 512'(io_cmd_yumi_o), 512'd0);
      tick();
      checkOutput("t2_stall_send", 512'(io_cmd_yumi_o), 512'd0);
      expectMem("t2_a", 40'h100, 64'hF0, 512'hDEADBEEF << 32);
      #1;
      checkOutput("t2_accept_after", 512'(io_cmd_yumi_o), 512'd1);
      tick();
      io_cmd_v_i = 1'b0;
      flush_i    = 1'b1;
      expectMem("t2_b", 40'h200, 64'hFF, 512'h1122334455667788);
      flush_i    = 1'b0;
      respPulse();
      respPulse();

      // 3: idle timeout after a single byte.
      applyStimulus(40'h40, 3'd0, 64'hA5);
      cyc = 0;
      while (!mem_cmd_v_o && cyc < 40) begin
         tick();
         cyc++;
      end
      checkOutput("t3_timeout_cycles", 512'(cyc), 512'd16);
      expectMem("t3", 40'h40, 64'h01, 512'hA5);
      respPulse();

      // 4: credit limit with responses withheld.
      fillBlock(40'h1000, 64'h100);
      expectMem("t4_a", 40'h1000, {64{1'b1}}, blockData(64'h100));
      fillBlock(40'h1040, 64'h200);
      expectMem("t4_b", 40'h1040, {64{1'b1}}, blockData(64'h200));
      fillBlock(40'h1080, 64'h300);
      checkOutput("t4_c_held", 512'(mem_cmd_v_o), 512'd0);
      tick();
      checkOutput("t4_c_still_held", 512'(mem_cmd_v_o), 512'd0);
      respPulse();
      checkOutput("t4_c_next_cycle", 512'(mem_cmd_v_o), 512'd1);
      checkOutput("t4_c_addr", 512'(mem_cmd_addr_o), 512'(40'h1080));
      mem_cmd_yumi_i = 1'b1;
      mem_resp_v_i   = 1'b1;
      tick();
      mem_cmd_yumi_i = 1'b0;
      mem_resp_v_i   = 1'b0;
      checkOutput("t4_c_gone", 512'(mem_cmd_v_o), 512'd0);
      fillBlock(40'h10C0, 64'h400);
      checkOutput("t4_d_credit", 512'(mem_cmd_v_o), 512'd1);
      expectMem("t4_d", 40'h10C0, {64{1'b1}}, blockData(64'h400));
      fillBlock(40'h1100, 64'h500);
      checkOutput("t4_count_two", 512'(mem_cmd_v_o), 512'd0);
      respPulse();
      expectMem("t4_e", 40'h1100, {64{1'b1}}, blockData(64'h500));
      respPulse();
      respPulse();
      tick();
      checkOutput("t4_done", 512'(flush_done_o), 512'd1);

      // 5: flush with acks held back.
      ack_q.delete();
      io_resp_ready_i = 1'b0;
      applyStimulus(40'h2002, 3'd1, 64'hBEEF);
      flush_i = 1'b1;
      expectMem("t5_a", 40'h2000, 64'h0C, 512'hBEEF << 16);
      applyStimulus(40'h2040, 3'd2, 64'hCAFEF00D);
      expectMem("t5_b", 40'h2040, 64'h0F, 512'hCAFEF00D);
      checkOutput("t5_done_out2", 512'(flush_done_o), 512'd0);
      respPulse();
      checkOutput("t5_done_out1", 512'(flush_done_o), 512'd0);
      respPulse();
      checkOutput("t5_done_acks", 512'(flush_done_o), 512'd0);
      io_resp_ready_i = 1'b1;
      repeat (3) tick();
      checkOutput("t5_done", 512'(flush_done_o), 512'd1);
      checkOutput("t5_ack_count", 512'(ack_q.size()), 512'd2);
      checkOutput("t5_ack0", 512'(ack_q[0]), 512'({3'd1, 40'h2002}));
      checkOutput("t5_ack1", 512'(ack_q[1]), 512'({3'd2, 40'h2040}));
      flush_i = 1'b0;

      // 6: reset in the middle of a fill with one write outstanding.
      applyStimulus(40'h3000, 3'd3, 64'h0102030405060708);
      flush_i = 1'b1;
      expectMem("t6_a", 40'h3000, 64'hFF, 512'h0102030405060708);
      flush_i = 1'b0;
      applyStimulus(40'h3040, 3'd0, 64'h77);
      reset_n_i = 1'b0;
      tick();
      checkOutput("t6_rst_mem_v", 512'(mem_cmd_v_o), 512'd0);
      checkOutput("t6_rst_resp_v", 512'(io_resp_v_o), 512'd0);
      checkOutput("t6_rst_cmd_yumi", 512'(io_cmd_yumi_o), 512'd0);
      reset_n_i = 1'b1;
      respPulse();
      checkOutput("t6_done_after_rst", 512'(flush_done_o), 512'd1);
      applyStimulus(40'h3041, 3'd0, 64'h5A);
      flush_i = 1'b1;
      expectMem("t6_b", 40'h3040, 64'h02, 512'h5A00);
      flush_i = 1'b0;
      respPulse();
      tick();
      checkOutput("t6_done", 512'(flush_done_o), 512'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
